// File: rtl/alu_cmd_issuer.sv
// Command-side issuer for the 2-bit ALU datapath: registers a command into the datapath,
// waits SETTLE cycles, then returns the selected lane. Optional echo check: ISSUER_ECHO_CHECK_EN.
module alu_cmd_issuer #(
    parameter int SETTLE = 1,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [7:0]       cmd_instr,
    input  logic [1:0]       cmd_a,
    input  logic [1:0]       cmd_b,
    output logic [1:0]       dp_data0,
    output logic [1:0]       dp_data1,
    output logic [7:0]       dp_instr,
    input  logic [1:0]       dp_out0,
    input  logic [1:0]       dp_out1,
    input  logic [1:0]       dp_out2,
    input  logic [1:0]       dp_out3,
    input  logic             dp_ok,
    input  logic [1:0]       dp_overflag,
    input  logic [7:0]       dp_instr_echo,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [1:0]       rsp_data,
    output logic             rsp_ok,
    output logic [1:0]       rsp_over,
    output logic             rsp_err,
    output logic [CNT_W-1:0] issued_cnt
);

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

    state_t     state, state_nxt;
    logic [3:0] settle_cnt;
    logic       accept, capture;
    logic [1:0] lane_val;

    assign accept  = cmd_valid & cmd_ready;
    assign capture = (state == WAIT) && (settle_cnt == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = WAIT;
            WAIT:    if (capture) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == IDLE);
        rsp_valid = (state == RESP);
    end

    // Datapath inputs only move on accept so the combinational datapath never sees a glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_data0   <= '0;
            dp_data1   <= '0;
            dp_instr   <= '0;
            issued_cnt <= '0;
        end else if (accept) begin
            dp_data0   <= cmd_a;
            dp_data1   <= cmd_b;
            dp_instr   <= cmd_instr;
            issued_cnt <= issued_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               settle_cnt <= '0;
        else if (accept)                          settle_cnt <= 4'(SETTLE - 1);
        else if (state == WAIT && !capture)       settle_cnt <= settle_cnt - 4'd1;
    end

    always_comb begin
        case (dp_instr[4:3])
            2'd1:    lane_val = dp_out1;
            2'd2:    lane_val = dp_out2;
            2'd3:    lane_val = dp_out3;
            default: lane_val = dp_out0;
        endcase
    end

    // Record is held after the handshake; only the next capture overwrites it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data <= '0;
            rsp_ok   <= 1'b0;
            rsp_over <= '0;
        end else if (capture) begin
            rsp_data <= lane_val;
            rsp_ok   <= dp_ok;
            rsp_over <= dp_overflag;
        end
    end

`ifdef ISSUER_ECHO_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       rsp_err <= 1'b0;
        else if (capture) rsp_err <= (dp_instr_echo != dp_instr);
    end
`else
    logic [7:0] unused_echo;
    assign unused_echo = dp_instr_echo;
    assign rsp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer: SETTLE=1 instance for function/back-pressure/wrap,
// SETTLE=4 instance for latency and mid-WAIT reset. Datapath is a behavioural stub.
module tb_alu_cmd_issuer;

`ifdef ISSUER_ECHO_CHECK_EN
    localparam bit ECHO = 1'b1;
`else
    localparam bit ECHO = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_cnt = 8'd0;

    // SETTLE = 1 instance
    logic       rst_n, cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_ok, rsp_err, dp_ok;
    logic [7:0] cmd_instr, dp_instr, dp_echo, issued_cnt, ln1;
    logic [1:0] cmd_a, cmd_b, dp_data0, dp_data1, rsp_data, rsp_over, dp_over;

    // SETTLE = 4 instance
    logic       rst4_n, cmd4_valid, cmd4_ready, rsp4_valid, rsp4_ready, rsp4_ok, rsp4_err, dp4_ok;
    logic [7:0] cmd4_instr, dp4_instr, dp4_echo, issued4_cnt, ln4;
    logic [1:0] cmd4_a, cmd4_b, dp4_data0, dp4_data1, rsp4_data, rsp4_over, dp4_over;

    // Stub datapath: mux sel 0 add, 1 and, 2 xor (special), 3 zero; demux to one lane.
    function automatic logic [7:0] dp_lanes(input logic [1:0] a, input logic [1:0] b, input logic [7:0] i);
        logic [1:0] r;
        logic [7:0] v;
        case (i[2:1])
            2'd0:    r = a + b;
            2'd1:    r = a & b;
            2'd2:    r = a ^ b;
            default: r = 2'd0;
        endcase
        v = 8'd0;
        v[{i[4:3], 1'b0} +: 2] = r;
        return v;
    endfunction

    function automatic logic [1:0] dp_carry(input logic [1:0] a, input logic [1:0] b);
        return {1'b0, (({1'b0, a} + {1'b0, b}) > 3'd3)};
    endfunction

    assign ln1      = dp_lanes(dp_data0, dp_data1, dp_instr);
    assign dp_ok    = ~dp_instr[7];
    assign dp_over  = dp_carry(dp_data0, dp_data1);
    assign dp_echo  = (dp_instr == 8'h00) ? 8'hFF : dp_instr;
    assign ln4      = dp_lanes(dp4_data0, dp4_data1, dp4_instr);
    assign dp4_ok   = ~dp4_instr[7];
    assign dp4_over = dp_carry(dp4_data0, dp4_data1);
    assign dp4_echo = (dp4_instr == 8'h00) ? 8'hFF : dp4_instr;

    alu_cmd_issuer #(.SETTLE(1), .CNT_W(8)) u1 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_instr(cmd_instr), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .dp_data0(dp_data0), .dp_data1(dp_data1), .dp_instr(dp_instr),
        .dp_out0(ln1[1:0]), .dp_out1(ln1[3:2]), .dp_out2(ln1[5:4]), .dp_out3(ln1[7:6]),
        .dp_ok(dp_ok), .dp_overflag(dp_over), .dp_instr_echo(dp_echo),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_ok(rsp_ok), .rsp_over(rsp_over), .rsp_err(rsp_err), .issued_cnt(issued_cnt)
    );

    alu_cmd_issuer #(.SETTLE(4), .CNT_W(8)) u4 (
        .clk(clk), .rst_n(rst4_n), .cmd_valid(cmd4_valid), .cmd_ready(cmd4_ready),
        .cmd_instr(cmd4_instr), .cmd_a(cmd4_a), .cmd_b(cmd4_b),
        .dp_data0(dp4_data0), .dp_data1(dp4_data1), .dp_instr(dp4_instr),
        .dp_out0(ln4[1:0]), .dp_out1(ln4[3:2]), .dp_out2(ln4[5:4]), .dp_out3(ln4[7:6]),
        .dp_ok(dp4_ok), .dp_overflag(dp4_over), .dp_instr_echo(dp4_echo),
        .rsp_valid(rsp4_valid), .rsp_ready(rsp4_ready), .rsp_data(rsp4_data),
        .rsp_ok(rsp4_ok), .rsp_over(rsp4_over), .rsp_err(rsp4_err), .issued_cnt(issued4_cnt)
    );

    // Directed vectors: instr, a, b -> lane value, ok, over
    localparam logic [7:0] V_INSTR [6] = '{8'h00, 8'h12, 8'h1C, 8'h88, 8'h16, 8'h0A};
    localparam logic [1:0] V_A     [6] = '{2'd1, 2'd3, 2'd1, 2'd3, 2'd3, 2'd1};
    localparam logic [1:0] V_B     [6] = '{2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3};
    localparam logic [1:0] V_DATA  [6] = '{2'd3, 2'd2, 2'd3, 2'd2, 2'd0, 2'd1};
    localparam logic       V_OK    [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    localparam logic [1:0] V_OVER  [6] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd1, 2'd1};

    task automatic test_reset;
        cmd_valid = 1'b1; cmd_instr = 8'h08; cmd_a = 2'd1; cmd_b = 2'd1;
        repeat (2) @(negedge clk);
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_cmd_ready: got %0h want 1", cmd_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid: got %0h want 0", rsp_valid); end
        n_cmp++; if (dp_data0 !== 2'd0) begin n_bad++; $display("FAIL rst_dp_data0: got %0h want 0", dp_data0); end
        n_cmp++; if (dp_data1 !== 2'd0) begin n_bad++; $display("FAIL rst_dp_data1: got %0h want 0", dp_data1); end
        n_cmp++; if (dp_instr !== 8'd0) begin n_bad++; $display("FAIL rst_dp_instr: got %0h want 0", dp_instr); end
        n_cmp++; if (issued_cnt !== 8'd0) begin n_bad++; $display("FAIL rst_issued_cnt: got %0h want 0", issued_cnt); end
        n_cmp++; if ({rsp_data, rsp_ok, rsp_over, rsp_err} !== 6'd0) begin n_bad++;
            $display("FAIL rst_rsp_fields: got %0h want 0", {rsp_data, rsp_ok, rsp_over, rsp_err}); end
        rst_n = 1'b1; rst4_n = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        exp_cnt = 8'd1;
        n_cmp++; if (dp_instr !== 8'h08) begin n_bad++; $display("FAIL first_accept_instr: got %0h want 08", dp_instr); end
        n_cmp++; if ({dp_data0, dp_data1} !== 4'b0101) begin n_bad++; $display("FAIL first_accept_data: got %0h want 5", {dp_data0, dp_data1}); end
        n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL first_accept_ready: got %0h want 0", cmd_ready); end
        n_cmp++; if (issued_cnt !== exp_cnt) begin n_bad++; $display("FAIL first_accept_cnt: got %0h want %0h", issued_cnt, exp_cnt); end
        @(posedge clk); #1;
        n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL first_rsp_valid: got %0h want 1", rsp_valid); end
        n_cmp++; if (rsp_data !== 2'd2) begin n_bad++; $display("FAIL first_rsp_data: got %0h want 2", rsp_data); end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        n_cmp++; if ({cmd_ready, rsp_valid} !== 2'b10) begin n_bad++; $display("FAIL first_return_idle: got %0h want 2", {cmd_ready, rsp_valid}); end
    endtask

    task automatic test_vectors;
        for (int v = 0; v < 6; v++) begin
            cmd_instr = V_INSTR[v]; cmd_a = V_A[v]; cmd_b = V_B[v]; cmd_valid = 1'b1;
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            exp_cnt++;
            n_cmp++; if (dp_instr !== V_INSTR[v]) begin n_bad++; $display("FAIL vec%0d_dp_instr: got %0h want %0h", v, dp_instr, V_INSTR[v]); end
            n_cmp++; if (issued_cnt !== exp_cnt) begin n_bad++; $display("FAIL vec%0d_cnt: got %0h want %0h", v, issued_cnt, exp_cnt); end
            n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL vec%0d_early_valid: got %0h want 0", v, rsp_valid); end
            @(posedge clk); #1;
            n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL vec%0d_rsp_valid: got %0h want 1", v, rsp_valid); end
            n_cmp++; if (rsp_data !== V_DATA[v]) begin n_bad++; $display("FAIL vec%0d_rsp_data: got %0h want %0h", v, rsp_data, V_DATA[v]); end
            n_cmp++; if (rsp_ok !== V_OK[v]) begin n_bad++; $display("FAIL vec%0d_rsp_ok: got %0h want %0h", v, rsp_ok, V_OK[v]); end
            n_cmp++; if (rsp_over !== V_OVER[v]) begin n_bad++; $display("FAIL vec%0d_rsp_over: got %0h want %0h", v, rsp_over, V_OVER[v]); end
            n_cmp++; if (rsp_err !== (ECHO && V_INSTR[v] == 8'h00)) begin n_bad++;
                $display("FAIL vec%0d_rsp_err: got %0h want %0h", v, rsp_err, (ECHO && V_INSTR[v] == 8'h00)); end
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_back_pressure;
        cmd_instr = 8'h00; cmd_a = 2'd2; cmd_b = 2'd1; cmd_valid = 1'b1;
        @(posedge clk); #1;
        exp_cnt++;
        @(posedge clk); #1;
        cmd_instr = 8'h12; cmd_a = 2'd3; cmd_b = 2'd2;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++; if ({rsp_valid, rsp_data, cmd_ready} !== 4'b1110) begin n_bad++;
                $display("FAIL bp_hold%0d: got valid/data/ready %0h want e", i, {rsp_valid, rsp_data, cmd_ready}); end
            n_cmp++; if (issued_cnt !== exp_cnt || dp_instr !== 8'h00) begin n_bad++;
                $display("FAIL bp_no_accept%0d: got cnt %0h instr %0h want %0h 00", i, issued_cnt, dp_instr, exp_cnt); end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        n_cmp++; if ({cmd_ready, rsp_valid} !== 2'b10) begin n_bad++; $display("FAIL bp_idle: got %0h want 2", {cmd_ready, rsp_valid}); end
        n_cmp++; if (rsp_data !== 2'd3) begin n_bad++; $display("FAIL bp_record_held: got %0h want 3", rsp_data); end
        n_cmp++; if (issued_cnt !== exp_cnt) begin n_bad++; $display("FAIL bp_cnt_before: got %0h want %0h", issued_cnt, exp_cnt); end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        exp_cnt++;
        n_cmp++; if (issued_cnt !== exp_cnt || dp_instr !== 8'h12) begin n_bad++;
            $display("FAIL bp_second_accept: got cnt %0h instr %0h want %0h 12", issued_cnt, dp_instr, exp_cnt); end
        @(posedge clk); #1;
        n_cmp++; if ({rsp_valid, rsp_data} !== 3'b110) begin n_bad++; $display("FAIL bp_second_rsp: got %0h want 6", {rsp_valid, rsp_data}); end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_settle4_reset_mid_wait;
        logic seen;
        cmd4_instr = 8'h12; cmd4_a = 2'd3; cmd4_b = 2'd2; cmd4_valid = 1'b1;
        @(posedge clk); #1;
        cmd4_valid = 1'b0;
        n_cmp++; if ({cmd4_ready, dp4_instr, issued4_cnt} !== {1'b0, 8'h12, 8'd1}) begin n_bad++;
            $display("FAIL s4_accept: got %0h want 01201", {cmd4_ready, dp4_instr, issued4_cnt}); end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (rsp4_valid !== 1'b0) begin n_bad++; $display("FAIL s4_early_valid: got %0h want 0", rsp4_valid); end
        @(posedge clk); #1;
        n_cmp++; if ({rsp4_valid, rsp4_data} !== 3'b110) begin n_bad++; $display("FAIL s4_rsp: got %0h want 6", {rsp4_valid, rsp4_data}); end
        @(posedge clk); #1;
        n_cmp++; if (cmd4_ready !== 1'b1) begin n_bad++; $display("FAIL s4_idle: got %0h want 1", cmd4_ready); end
        cmd4_instr = 8'h00; cmd4_a = 2'd1; cmd4_b = 2'd1; cmd4_valid = 1'b1;
        @(posedge clk); #1;
        cmd4_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst4_n = 1'b0;
        #1;
        n_cmp++; if ({cmd4_ready, rsp4_valid} !== 2'b10) begin n_bad++; $display("FAIL s4_rst_ctrl: got %0h want 2", {cmd4_ready, rsp4_valid}); end
        n_cmp++; if ({dp4_data0, dp4_data1, dp4_instr, issued4_cnt} !== 20'd0) begin n_bad++;
            $display("FAIL s4_rst_dp: got %0h want 0", {dp4_data0, dp4_data1, dp4_instr, issued4_cnt}); end
        n_cmp++; if ({rsp4_data, rsp4_ok, rsp4_over, rsp4_err} !== 6'd0) begin n_bad++;
            $display("FAIL s4_rst_rsp: got %0h want 0", {rsp4_data, rsp4_ok, rsp4_over, rsp4_err}); end
        @(negedge clk);
        rst4_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp4_valid) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL s4_aborted_rsp: got %0h want 0", seen); end
    endtask

    task automatic test_wrap;
        int n, timeouts, guard;
        n = 256 - int'(exp_cnt);
        timeouts = 0;
        rsp_ready = 1'b1;
        cmd_instr = 8'h12; cmd_a = 2'd1; cmd_b = 2'd3;
        for (int k = 0; k < n; k++) begin
            guard = 0;
            while (!cmd_ready && guard < 10) begin
                @(posedge clk); #1;
                guard++;
            end
            if (guard == 10) timeouts++;
            cmd_valid = 1'b1;
            @(posedge clk); #1;
            cmd_valid = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        n_cmp++; if (timeouts != 0) begin n_bad++; $display("FAIL wrap_timeouts: got %0d want 0", timeouts); end
        n_cmp++; if (issued_cnt !== 8'd0) begin n_bad++; $display("FAIL wrap_cnt: got %0h want 0", issued_cnt); end
    endtask

    initial begin
        rst_n = 1'b1; rst4_n = 1'b1;
        cmd_valid = 1'b0; cmd_instr = 8'h00; cmd_a = 2'd0; cmd_b = 2'd0; rsp_ready = 1'b0;
        cmd4_valid = 1'b0; cmd4_instr = 8'h00; cmd4_a = 2'd0; cmd4_b = 2'd0; rsp4_ready = 1'b1;
        #2;
        rst_n = 1'b0; rst4_n = 1'b0;
        test_reset;
        test_vectors;
        test_back_pressure;
        test_settle4_reset_mid_wait;
        test_wrap;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
